// File: rtl/rr_arbiter_3.sv
// ============================================================================
// Module  : rr_arbiter_3
// Brief   : Three-way round-robin arbiter with completion hand-off and a
//           bounded hold time; drives one-hot grants and a 3:1 mux select.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter_3 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic [2:0] req,
    input  logic       done,
    output logic [2:0] grant,
    output logic [1:0] select,
    output logic       busy
);

    localparam int            c_CW       = (CNT_W < 1) ? 1 : CNT_W;
    localparam bit            c_LIMIT_EN = (MAX_HOLD != 0);
    localparam logic [c_CW-1:0] c_CNT_LAST =
        (MAX_HOLD == 0) ? '0 : c_CW'(MAX_HOLD - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t            r_state;
    logic [2:0]        r_grant;
    logic [1:0]        r_select;
    logic [1:0]        r_ptr;
    logic [c_CW-1:0]   r_cnt;

    logic [1:0]        w_win;
    logic [2:0]        w_win_oh;
    logic              w_others;
    logic              w_abort;
    logic              w_at_limit;
    logic              w_preempt;
    logic              w_release;

    // Search order is ptr+1, ptr+2, then ptr itself, so the last owner only
    // wins again when nobody else is asking.
    function automatic logic [1:0] f_arb(input logic [2:0] r, input logic [1:0] p);
        logic [1:0] c1;
        logic [1:0] c2;
        c1 = (p == 2'd2) ? 2'd0 : p + 2'd1;
        c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
        if (r[c1])
            return c1;
        else if (r[c2])
            return c2;
        else
            return p;
    endfunction

    always_comb begin
        w_win      = f_arb(req, r_ptr);
        w_win_oh   = 3'b001 << w_win;
        w_others   = |(req & ~r_grant);
        w_abort    = ~|(req & r_grant);
        w_at_limit = c_LIMIT_EN && (r_cnt == c_CNT_LAST);
        w_preempt  = w_at_limit && w_others;
        w_release  = done || w_abort || w_preempt;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state  <= S_IDLE;
            r_grant  <= 3'b000;
            r_select <= 2'd0;
            r_ptr    <= 2'd2;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_grant  <= w_win_oh;
                        r_select <= w_win;
                        r_ptr    <= w_win;
                        r_cnt    <= '0;
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (w_release) begin
                        r_cnt <= '0;
                        // Hand straight to the next winner so the resource sees no bubble.
                        if (|req) begin
                            r_grant  <= w_win_oh;
                            r_select <= w_win;
                            r_ptr    <= w_win;
                        end else begin
                            r_grant <= 3'b000;
                            r_state <= S_IDLE;
                        end
                    end else if (!c_LIMIT_EN || w_at_limit) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= 3'b000;
                end
            endcase
        end
    end

    assign grant  = r_grant;
    assign select = r_select;
    assign busy   = |r_grant;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter_3.sv
// ============================================================================
// Module  : tb_rr_arbiter_3
// Brief   : Directed and randomized self-checking bench for rr_arbiter_3.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_arbiter_3;

    logic       clk;
    logic       arst_n;
    logic [2:0] req;
    logic       done;
    logic [2:0] grant;
    logic [1:0] select;
    logic       busy;

    int checks;
    int errors;

    rr_arbiter_3 #(.MAX_HOLD(4)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .req    (req),
        .done   (done),
        .grant  (grant),
        .select (select),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req    = 3'b000;
        done   = 1'b0;
        arst_n = 1'b0;
        @(posedge clk);
        #3;
        arst_n = 1'b1;
    endtask

    task automatic test_reset();
        req    = 3'b000;
        done   = 1'b0;
        arst_n = 1'b0;
        #12;
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL reset_grant: got %b expected 000", grant); end
        checks++; if (select !== 2'b00) begin errors++; $display("FAIL reset_select: got %b expected 00", select); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(posedge clk);
        #3;
        arst_n = 1'b1;
        done = 1'b1;
        step();
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL idle_done_ignored: got %b expected 000", grant); end
        done = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        req = 3'b001;
        step();
        checks++; if (grant !== 3'b001) begin errors++; $display("FAIL basic_grant: got %b expected 001", grant); end
        checks++; if (select !== 2'b00) begin errors++; $display("FAIL basic_select: got %b expected 00", select); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
        step();
        step();
        checks++; if (grant !== 3'b001) begin errors++; $display("FAIL basic_hold: got %b expected 001", grant); end
        req  = 3'b000;
        done = 1'b1;
        step();
        done = 1'b0;
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL basic_release: got %b expected 000", grant); end
        checks++; if (select !== 2'b00) begin errors++; $display("FAIL basic_select_hold: got %b expected 00", select); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_clear: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_g [4];
        logic [1:0] exp_s [4];
        exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_s = '{2'd0, 2'd1, 2'd2, 2'd0};
        do_reset();
        req = 3'b111;
        step();
        for (int k = 0; k < 4; k++) begin
            // first cycle of this grant
            checks++; if (grant !== exp_g[k]) begin errors++; $display("FAIL b2b_grant%0d_first: got %b expected %b", k, grant, exp_g[k]); end
            checks++; if (select !== exp_s[k]) begin errors++; $display("FAIL b2b_select%0d: got %b expected %b", k, select, exp_s[k]); end
            done = 1'b0;
            step();
            checks++; if (grant !== exp_g[k]) begin errors++; $display("FAIL b2b_grant%0d_second: got %b expected %b", k, grant, exp_g[k]); end
            done = 1'b1;
            step();
        end
        done = 1'b0;
    endtask

    task automatic test_preempt();
        do_reset();
        req = 3'b011;
        step();
        for (int k = 0; k < 4; k++) begin
            checks++; if (grant !== 3'b001) begin errors++; $display("FAIL preempt_hold%0d: got %b expected 001", k, grant); end
            if (k < 3) step();
        end
        step();
        checks++; if (grant !== 3'b010) begin errors++; $display("FAIL preempt_switch: got %b expected 010", grant); end
        checks++; if (select !== 2'b01) begin errors++; $display("FAIL preempt_select: got %b expected 01", select); end

        do_reset();
        req = 3'b001;
        for (int k = 0; k < 12; k++) begin
            step();
            checks++; if (grant !== 3'b001) begin errors++; $display("FAIL sole_owner_cycle%0d: got %b expected 001", k, grant); end
        end

        // done coinciding with the hold limit must re-arbitrate only once
        do_reset();
        req = 3'b111;
        step();
        step();
        step();
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        checks++; if (grant !== 3'b010) begin errors++; $display("FAIL done_preempt_grant: got %b expected 010", grant); end
        step();
        checks++; if (grant !== 3'b010) begin errors++; $display("FAIL done_preempt_single: got %b expected 010", grant); end
    endtask

    task automatic test_abort();
        do_reset();
        req = 3'b011;
        step();
        req  = 3'b110;
        done = 1'b1;
        step();
        done = 1'b0;
        checks++; if (grant !== 3'b010) begin errors++; $display("FAIL abort_setup: got %b expected 010", grant); end
        req = 3'b011;
        step();
        checks++; if (grant !== 3'b010) begin errors++; $display("FAIL nonowner_change: got %b expected 010", grant); end
        req = 3'b100;
        step();
        checks++; if (grant !== 3'b100) begin errors++; $display("FAIL abort_grant: got %b expected 100", grant); end
        checks++; if (select !== 2'b10) begin errors++; $display("FAIL abort_select: got %b expected 10", select); end
        req = 3'b000;
        step();
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL abort_idle: got %b expected 000", grant); end
        checks++; if (select !== 2'b10) begin errors++; $display("FAIL idle_select_hold: got %b expected 10", select); end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 3'b010;
        step();
        checks++; if (grant !== 3'b010) begin errors++; $display("FAIL areset_setup: got %b expected 010", grant); end
        req = 3'b110;
        #2;
        arst_n = 1'b0;
        #1;
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL areset_grant: got %b expected 000", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b expected 0", busy); end
        checks++; if (select !== 2'b00) begin errors++; $display("FAIL areset_select: got %b expected 00", select); end
        #2;
        arst_n = 1'b1;
        step();
        checks++; if (grant !== 3'b010) begin errors++; $display("FAIL areset_first_arb: got %b expected 010", grant); end
    endtask

    task automatic test_random();
        int         waits [3];
        logic [2:0] prev_grant;
        logic [2:0] nreq;
        logic       new_grant;
        do_reset();
        waits      = '{0, 0, 0};
        prev_grant = grant;
        for (int c = 0; c < 2000; c++) begin
            nreq = req;
            for (int i = 0; i < 3; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(1, 0) == 1) nreq[i] = 1'b1;
                end else if (grant[i] && $urandom_range(3, 0) == 0) begin
                    nreq[i] = 1'b0;
                end
            end
            req  = nreq;
            done = busy && ($urandom_range(2, 0) == 0);
            step();
            new_grant = (grant != 3'b000) && (grant != prev_grant);
            checks++; if (!(grant == 3'b000 || grant == 3'b001 || grant == 3'b010 || grant == 3'b100)) begin errors++; $display("FAIL rand_onehot cycle %0d: got %b expected one-hot or 000", c, grant); end
            checks++; if (select === 2'b11) begin errors++; $display("FAIL rand_select cycle %0d: got %b expected not 11", c, select); end
            checks++; if (busy !== (|grant)) begin errors++; $display("FAIL rand_busy cycle %0d: got %b expected %b", c, busy, |grant); end
            for (int i = 0; i < 3; i++) begin
                if (grant[i] || !req[i])
                    waits[i] = 0;
                else if (new_grant)
                    waits[i] = waits[i] + 1;
                checks++; if (waits[i] > 2) begin errors++; $display("FAIL rand_starve req%0d cycle %0d: got %0d grants waited expected at most 2", i, c, waits[i]); end
            end
            prev_grant = grant;
        end
        req  = 3'b000;
        done = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        req    = 3'b000;
        done   = 1'b0;
        arst_n = 1'b1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_preempt();
        test_abort();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
